// File: rtl/ps2_keyboard_rx_pkg.sv
// PS/2 keyboard receiver shared definitions.
// Prefix codes, frame FSM encoding and a parity helper.
package ps2_keyboard_rx_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity over the 8 data bits plus parity bit.
    function automatic logic odd_ok(
        input logic [7:0] data,
        input logic       par
    );
        return ^{par, data};
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Decoded key event bundle from the PS/2 receiver.
// master drives the events, slave consumes them.
interface ps2_keyboard_rx_if;
    import ps2_keyboard_rx_pkg::*;

    logic [7:0] scan_code;
    logic       extended;
    logic       key_released;
    logic       code_valid;
    logic       frame_err;
    logic       p1_pressed;
    logic       p2_pressed;

    modport master (
        output scan_code,
        output extended,
        output key_released,
        output code_valid,
        output frame_err,
        output p1_pressed,
        output p2_pressed
    );

    modport slave (
        input scan_code,
        input extended,
        input key_released,
        input code_valid,
        input frame_err,
        input p1_pressed,
        input p2_pressed
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// Pin conditioning: 2-FF synchroniser, run-length glitch
// filter and optional filtered falling-edge strobe.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8,
    parameter bit EDGE_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic level,
    output logic fall
);
    import ps2_keyboard_rx_pkg::*;

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic          filt_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // Two-stage synchroniser, idles high like the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pin};
        end
    end

    // Accept a new level only after FILTER_LEN equal samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
                fall_q <= EDGE_EN & ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign sync  = sync_q[1];
    assign level = filt_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame FSM, prefix decode
// and player key-held levels.
module ps2_keyboard_rx #(
    parameter int         FILTER_LEN     = 8,
    parameter int         TIMEOUT_CYCLES = 65000,
    parameter logic [7:0] KEY_P1         = 8'h1C,
    parameter logic [7:0] KEY_P2         = 8'h4B
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_keyboard_rx_if.master rx
);
    import ps2_keyboard_rx_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic fall;
    logic clk_sync;
    logic clk_level;
    logic data_s;
    logic data_level;
    logic data_fall;
    logic unused_pins;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN),
        .EDGE_EN    (1'b1)
    ) u_clk_filt (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_clk),
        .sync  (clk_sync),
        .level (clk_level),
        .fall  (fall)
    );

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN),
        .EDGE_EN    (1'b0)
    ) u_data_filt (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_data),
        .sync  (data_s),
        .level (data_level),
        .fall  (data_fall)
    );

    assign unused_pins = ^{clk_sync, clk_level,
                           data_level, data_fall};

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          good;
    logic          bad;

    logic [7:0] scan_q;
    logic       ext_out_q;
    logic       rel_out_q;
    logic       cv_q;
    logic       err_q;
    logic       p1_q;
    logic       p2_q;
    logic       ext_flag_q;
    logic       brk_flag_q;

    // Frame state, bit counter, shifter and timeout registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state: advance on edge strobe, bail out on timeout.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tmo_d   = tmo_q;
        good    = 1'b0;
        bad     = 1'b0;
        if (state_q == IDLE || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        bad = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = {data_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_s && odd_ok(shift_q, par_q)) begin
                        good = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE &&
                     tmo_q == TW'(TIMEOUT_CYCLES)) begin
            state_d = IDLE;
            tmo_d   = '0;
        end
    end

    // Registered byte decode, prefix flags and key levels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_q     <= '0;
            ext_out_q  <= 1'b0;
            rel_out_q  <= 1'b0;
            cv_q       <= 1'b0;
            err_q      <= 1'b0;
            p1_q       <= 1'b0;
            p2_q       <= 1'b0;
            ext_flag_q <= 1'b0;
            brk_flag_q <= 1'b0;
        end else begin
            cv_q  <= 1'b0;
            err_q <= 1'b0;
            if (good) begin
                unique case (1'b1)
                    (shift_q == PS2_BREAK): brk_flag_q <= 1'b1;
                    (shift_q == PS2_EXT):   ext_flag_q <= 1'b1;
                    default: begin
                        scan_q     <= shift_q;
                        ext_out_q  <= ext_flag_q;
                        rel_out_q  <= brk_flag_q;
                        cv_q       <= 1'b1;
                        ext_flag_q <= 1'b0;
                        brk_flag_q <= 1'b0;
                        if (!ext_flag_q && shift_q == KEY_P1) begin
                            p1_q <= ~brk_flag_q;
                        end
                        if (!ext_flag_q && shift_q == KEY_P2) begin
                            p2_q <= ~brk_flag_q;
                        end
                    end
                endcase
            end else if (bad) begin
                err_q      <= 1'b1;
                ext_flag_q <= 1'b0;
                brk_flag_q <= 1'b0;
            end
        end
    end

    assign rx.scan_code    = scan_q;
    assign rx.extended     = ext_out_q;
    assign rx.key_released = rel_out_q;
    assign rx.code_valid   = cv_q;
    assign rx.frame_err    = err_q;
    assign rx.p1_pressed   = p1_q;
    assign rx.p2_pressed   = p2_q;

endmodule
